// File: rtl/can_frame_receiver_if.sv
// Bus-side and decoded-frame signals of the CAN receive path.
// The bench or top level holds the master end; the receiver holds the slave end.
interface can_frame_receiver_if;
    logic        i_sample_en;
    logic        i_rx_bus;
    logic        o_ack_drive;
    logic [10:0] o_rx_id;
    logic        o_rx_rtr;
    logic [3:0]  o_rx_dlc;
    logic [63:0] o_rx_data;
    logic        o_frame_valid;
    logic        o_crc_error;
    logic        o_stuff_error;
    logic        o_form_error;
    logic        o_busy;

    modport master (
        output i_sample_en, i_rx_bus,
        input  o_ack_drive, o_rx_id, o_rx_rtr, o_rx_dlc, o_rx_data,
        input  o_frame_valid, o_crc_error, o_stuff_error, o_form_error, o_busy
    );

    modport slave (
        input  i_sample_en, i_rx_bus,
        output o_ack_drive, o_rx_id, o_rx_rtr, o_rx_dlc, o_rx_data,
        output o_frame_valid, o_crc_error, o_stuff_error, o_form_error, o_busy
    );
endinterface

// File: rtl/can_frame_receiver.sv
// CAN 2.0A receive path: bus integration, destuffing, field decode, CRC-15 check and ACK drive.
// All bit-level state advances only on the sample-point strobe.
module can_frame_receiver #(
    parameter int IDLE_BITS = 11
) (
    input  logic                clk,
    input  logic                rst,
    can_frame_receiver_if.slave bus
);
    localparam int          CNT_W    = $clog2(IDLE_BITS + 1);
    localparam logic [14:0] CRC_POLY = 15'h4599;

    typedef enum logic [3:0] {
        S_INTEG, S_IDLE, S_ID, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_ERROR
    } state_e;

    state_e           r_state,       w_state_next;
    logic [CNT_W-1:0] r_rec_cnt,     w_rec_cnt_next;
    logic [6:0]       r_bit_cnt,     w_bit_cnt_next;
    logic [6:0]       r_nbits,       w_nbits_next;
    logic [2:0]       r_run_len,     w_run_len_next;
    logic             r_last_bit,    w_last_bit_next;
    logic [14:0]      r_crc,         w_crc_next;
    logic [14:0]      r_crc_rx,      w_crc_rx_next;
    logic             r_crc_bad,     w_crc_bad_next;
    logic [10:0]      r_id,          w_id_next;
    logic             r_rtr,         w_rtr_next;
    logic [3:0]       r_dlc,         w_dlc_next;
    logic [63:0]      r_data,        w_data_next;
    logic             r_ack,         w_ack_next;
    logic             r_frame_valid, w_frame_valid_next;
    logic             r_crc_error,   w_crc_error_next;
    logic             r_stuff_error, w_stuff_error_next;
    logic             r_form_error,  w_form_error_next;

    logic       w_bit;
    logic       w_err_stuff;
    logic       w_err_form;
    logic       w_err_crc;
    logic [3:0] w_dlc_shift;
    logic [3:0] w_bytes;

    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[14];
        return {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
    endfunction

    assign w_bit       = bus.i_rx_bus;
    assign w_dlc_shift = {r_dlc[2:0], w_bit};
    assign w_bytes     = (w_dlc_shift > 4'd8) ? 4'd8 : w_dlc_shift;

    always_comb begin
        w_state_next       = r_state;
        w_rec_cnt_next     = r_rec_cnt;
        w_bit_cnt_next     = r_bit_cnt;
        w_nbits_next       = r_nbits;
        w_run_len_next     = r_run_len;
        w_last_bit_next    = r_last_bit;
        w_crc_next         = r_crc;
        w_crc_rx_next      = r_crc_rx;
        w_crc_bad_next     = r_crc_bad;
        w_id_next          = r_id;
        w_rtr_next         = r_rtr;
        w_dlc_next         = r_dlc;
        w_data_next        = r_data;
        w_ack_next         = r_ack;
        w_frame_valid_next = 1'b0;
        w_crc_error_next   = 1'b0;
        w_stuff_error_next = 1'b0;
        w_form_error_next  = 1'b0;
        w_err_stuff        = 1'b0;
        w_err_form         = 1'b0;
        w_err_crc          = 1'b0;

        if (bus.i_sample_en) begin
            case (r_state)
                S_INTEG, S_ERROR: begin
                    if (!w_bit) begin
                        w_rec_cnt_next = '0;
                    end else if (r_rec_cnt == CNT_W'(IDLE_BITS - 1)) begin
                        w_rec_cnt_next = '0;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_rec_cnt_next = r_rec_cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (!w_bit) begin
                        w_state_next    = S_ID;
                        w_run_len_next  = 3'd1;
                        w_last_bit_next = 1'b0;
                        w_crc_next      = crc_step(15'h0000, 1'b0);
                        w_bit_cnt_next  = '0;
                        w_id_next       = '0;
                        w_rtr_next      = 1'b0;
                        w_dlc_next      = '0;
                        w_data_next     = '0;
                        w_crc_rx_next   = '0;
                        w_crc_bad_next  = 1'b0;
                    end
                end
                S_ID, S_CTRL, S_DATA, S_CRC: begin
                    if (r_run_len == 3'd5) begin
                        // Stuff bit: must differ from the run, feeds nothing but the run tracker.
                        w_err_stuff     = (w_bit == r_last_bit);
                        w_run_len_next  = 3'd1;
                        w_last_bit_next = w_bit;
                    end else begin
                        w_run_len_next  = (w_bit == r_last_bit) ? r_run_len + 3'd1 : 3'd1;
                        w_last_bit_next = w_bit;
                        w_bit_cnt_next  = r_bit_cnt + 7'd1;
                        if (r_state != S_CRC) begin
                            w_crc_next = crc_step(r_crc, w_bit);
                        end
                        case (r_state)
                            S_ID: begin
                                w_id_next = {r_id[9:0], w_bit};
                                if (r_bit_cnt == 7'd10) begin
                                    w_state_next   = S_CTRL;
                                    w_bit_cnt_next = '0;
                                end
                            end
                            S_CTRL: begin
                                if (r_bit_cnt == 7'd0) begin
                                    w_rtr_next = w_bit;
                                end
                                if (r_bit_cnt == 7'd1) begin
                                    w_err_form = w_bit;
                                end
                                if (r_bit_cnt >= 7'd3) begin
                                    w_dlc_next = w_dlc_shift;
                                end
                                if (r_bit_cnt == 7'd6) begin
                                    w_bit_cnt_next = '0;
                                    w_nbits_next   = {w_bytes, 3'b000};
                                    w_state_next   = (r_rtr || (w_bytes == 4'd0)) ? S_CRC : S_DATA;
                                end
                            end
                            S_DATA: begin
                                // Bit k of the payload lands at position 63-k: left-aligned, MSB first.
                                w_data_next[~r_bit_cnt[5:0]] = w_bit;
                                if (r_bit_cnt == r_nbits - 7'd1) begin
                                    w_state_next   = S_CRC;
                                    w_bit_cnt_next = '0;
                                end
                            end
                            default: begin
                                w_crc_rx_next = {r_crc_rx[13:0], w_bit};
                                if (r_bit_cnt == 7'd14) begin
                                    w_state_next   = S_CRC_DEL;
                                    w_bit_cnt_next = '0;
                                end
                            end
                        endcase
                    end
                end
                S_CRC_DEL: begin
                    if (!w_bit) begin
                        w_err_form = 1'b1;
                    end else begin
                        w_ack_next     = (r_crc == r_crc_rx);
                        w_crc_bad_next = (r_crc != r_crc_rx);
                        w_state_next   = S_ACK_SLOT;
                    end
                end
                S_ACK_SLOT: begin
                    w_ack_next   = 1'b0;
                    w_state_next = S_ACK_DEL;
                end
                S_ACK_DEL: begin
                    if (!w_bit) begin
                        w_err_form = 1'b1;
                    end else if (r_crc_bad) begin
                        w_err_crc = 1'b1;
                    end else begin
                        w_state_next   = S_EOF;
                        w_bit_cnt_next = '0;
                    end
                end
                S_EOF: begin
                    if (!w_bit) begin
                        w_err_form = 1'b1;
                    end else if (r_bit_cnt == 7'd6) begin
                        w_frame_valid_next = 1'b1;
                        w_state_next       = S_IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 7'd1;
                    end
                end
                default: begin
                    w_state_next = S_INTEG;
                end
            endcase

            if (w_err_stuff || w_err_form || w_err_crc) begin
                w_stuff_error_next = w_err_stuff;
                w_form_error_next  = !w_err_stuff && w_err_form;
                w_crc_error_next   = !w_err_stuff && !w_err_form && w_err_crc;
                w_ack_next         = 1'b0;
                w_rec_cnt_next     = '0;
                w_state_next       = S_ERROR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_INTEG;
            r_rec_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_nbits       <= '0;
            r_run_len     <= '0;
            r_last_bit    <= 1'b1;
            r_crc         <= '0;
            r_crc_rx      <= '0;
            r_crc_bad     <= 1'b0;
            r_id          <= '0;
            r_rtr         <= 1'b0;
            r_dlc         <= '0;
            r_data        <= '0;
            r_ack         <= 1'b0;
            r_frame_valid <= 1'b0;
            r_crc_error   <= 1'b0;
            r_stuff_error <= 1'b0;
            r_form_error  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rec_cnt     <= w_rec_cnt_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_nbits       <= w_nbits_next;
            r_run_len     <= w_run_len_next;
            r_last_bit    <= w_last_bit_next;
            r_crc         <= w_crc_next;
            r_crc_rx      <= w_crc_rx_next;
            r_crc_bad     <= w_crc_bad_next;
            r_id          <= w_id_next;
            r_rtr         <= w_rtr_next;
            r_dlc         <= w_dlc_next;
            r_data        <= w_data_next;
            r_ack         <= w_ack_next;
            r_frame_valid <= w_frame_valid_next;
            r_crc_error   <= w_crc_error_next;
            r_stuff_error <= w_stuff_error_next;
            r_form_error  <= w_form_error_next;
        end
    end

    assign bus.o_ack_drive   = r_ack;
    assign bus.o_rx_id       = r_id;
    assign bus.o_rx_rtr      = r_rtr;
    assign bus.o_rx_dlc      = r_dlc;
    assign bus.o_rx_data     = r_data;
    assign bus.o_frame_valid = r_frame_valid;
    assign bus.o_crc_error   = r_crc_error;
    assign bus.o_stuff_error = r_stuff_error;
    assign bus.o_form_error  = r_form_error;
    assign bus.o_busy        = (r_state != S_INTEG) && (r_state != S_IDLE);
endmodule
